if_stage_ctrl: RTL and testbench

- Fetch-side responder to the load-use hazard interface: owns the PC register and the IF/ID pipeline register.
- Obeys pc_write/ifid_write stall requests and branch redirects from EX.
- Drives a variable-latency instruction-memory request/response port.
- Sits between instruction memory and the decode stage; supplies ifid_rs1/ifid_rs2 to the hazard unit via ifid_instr.

---
 rtl/if_stage_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_if_stage_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage_ctrl.sv
// ----------------------------------------------------------------------------
// if_stage_ctrl
//
// Instruction-fetch stage controller. Owns the program counter and the IF/ID
// pipeline register, issues one instruction-memory request at a time over a
// variable-latency request/response port, obeys load-use stall requests from
// the hazard unit and takes branch redirects from EX.
//
// Optional feature (compile-time macro IF_STALL_CNT_EN):
//   When defined, adds output stall_cnt, a wrapping 32-bit count of cycles in
//   which the stage was stalled (advance low) without a branch redirect.
//
// Ports:
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   pc_write       in   0 = hold PC (hazard stall)
//   ifid_write     in   0 = hold IF/ID (hazard stall)
//   branch_taken   in   single-cycle redirect pulse from EX
//   branch_target  in   redirect address, bits [1:0] ignored
//   imem_req       out  fetch request strobe, one cycle per fetch
//   imem_addr      out  fetch address, valid while imem_req is high
//   imem_valid     in   fetch response strobe
//   imem_rdata     in   fetched instruction, valid with imem_valid
//   ifid_pc        out  PC of the instruction held in IF/ID
//   ifid_instr     out  instruction held in IF/ID (rs1/rs2 fields feed hazard unit)
//   ifid_valid     out  IF/ID holds a real instruction
//   fetch_busy     out  a request is outstanding
//   stall_cnt      out  stall cycle counter (IF_STALL_CNT_EN only)
// ----------------------------------------------------------------------------
module if_stage_ctrl #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,

    // Hazard unit / EX
    input  logic            pc_write,
    input  logic            ifid_write,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,

    // Instruction memory
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [31:0]     imem_rdata,

    // IF/ID register
    output logic [XLEN-1:0] ifid_pc,
    output logic [31:0]     ifid_instr,
    output logic            ifid_valid,

    output logic            fetch_busy
`ifdef IF_STALL_CNT_EN
    ,
    output logic [31:0]     stall_cnt
`endif
);

    // ------------------------------------------------------------------------
    // Types and state
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        StReq  = 2'd0,  // issue a request for pc
        StWait = 2'd1,  // request outstanding, waiting for the response
        StHold = 2'd2   // response captured during a stall, waiting to advance
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              squash_q, squash_d;
    logic [31:0]       hold_buf_q, hold_buf_d;
    logic [XLEN-1:0]   ifid_pc_q, ifid_pc_d;
    logic [31:0]       ifid_instr_q, ifid_instr_d;
    logic              ifid_valid_q, ifid_valid_d;

    logic              advance;
    logic [XLEN-1:0]   pc_inc;
    logic [XLEN-1:0]   redirect_pc;

    // Low address bits of the target are architecturally zero for 32-bit
    // instructions; they are dropped on purpose.
    logic              unused_target_lsb;
    assign unused_target_lsb = ^branch_target[1:0];

    assign advance     = pc_write & ifid_write;
    assign pc_inc      = pc_q + XLEN'(4);  // wraps modulo 2^XLEN
    assign redirect_pc = {branch_target[XLEN-1:2], 2'b00};

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        squash_d     = squash_q;
        hold_buf_d   = hold_buf_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;

        if (branch_taken) begin
            // Redirect wins over everything, including a stall. IF/ID gets a
            // bubble and any held instruction is abandoned.
            pc_d         = redirect_pc;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;

            unique case (state_q)
                StReq: begin
                    // The request issued this cycle is for the wrong path;
                    // its response must be thrown away.
                    state_d  = StWait;
                    squash_d = 1'b1;
                end
                StWait: begin
                    if (imem_valid) begin
                        // Stale response arrives now: drop it and refetch.
                        state_d  = StReq;
                        squash_d = 1'b0;
                    end else begin
                        // Still one response in flight; it will be dropped.
                        // Repeated redirects keep squash at 1, so exactly one
                        // response is discarded.
                        state_d  = StWait;
                        squash_d = 1'b1;
                    end
                end
                StHold: begin
                    state_d = StReq;
                end
                default: begin
                    state_d = StReq;
                end
            endcase
        end else begin
            unique case (state_q)
                StReq: begin
                    state_d = StWait;
                    if (advance) begin
                        ifid_instr_d = NOP_INSTR;
                        ifid_valid_d = 1'b0;
                    end
                end

                StWait: begin
                    if (!imem_valid) begin
                        if (advance) begin
                            ifid_instr_d = NOP_INSTR;
                            ifid_valid_d = 1'b0;
                        end
                    end else if (squash_q) begin
                        // Wrong-path response: discard, fetch from the new pc.
                        squash_d = 1'b0;
                        state_d  = StReq;
                        if (advance) begin
                            ifid_instr_d = NOP_INSTR;
                            ifid_valid_d = 1'b0;
                        end
                    end else if (advance) begin
                        ifid_pc_d    = pc_q;
                        ifid_instr_d = imem_rdata;
                        ifid_valid_d = 1'b1;
                        pc_d         = pc_inc;
                        state_d      = StReq;
                    end else begin
                        // Decode is stalled: park the instruction until it can
                        // move into IF/ID.
                        hold_buf_d = imem_rdata;
                        state_d    = StHold;
                    end
                end

                StHold: begin
                    if (advance) begin
                        ifid_pc_d    = pc_q;
                        ifid_instr_d = hold_buf_q;
                        ifid_valid_d = 1'b1;
                        pc_d         = pc_inc;
                        state_d      = StReq;
                    end
                end

                default: begin
                    state_d = StReq;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StReq;
            pc_q         <= RESET_PC;
            squash_q     <= 1'b0;
            hold_buf_q   <= NOP_INSTR;
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            squash_q     <= squash_d;
            hold_buf_q   <= hold_buf_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // The state resets to StReq so that the first fetch goes out on the first
    // cycle after release; the request strobe itself must stay low while reset
    // is held, hence the gating.
    assign imem_req   = rst_n & (state_q == StReq);
    assign imem_addr  = pc_q;
    assign fetch_busy = (state_q == StWait);

    assign ifid_pc    = ifid_pc_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_valid = ifid_valid_q;

`ifdef IF_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (!advance && !branch_taken) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage_ctrl.sv
// ----------------------------------------------------------------------------
// tb_if_stage_ctrl
//
// Directed self-checking bench for if_stage_ctrl. Inputs are driven and
// outputs sampled 1 time unit after each rising clock edge. Expected values
// are hand-computed constants.
// ----------------------------------------------------------------------------
module tb_if_stage_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        pc_write;
    logic        ifid_write;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic        fetch_busy;
`ifdef IF_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    if_stage_ctrl #(
        .XLEN      (32),
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_write      (pc_write),
        .ifid_write    (ifid_write),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_valid    (imem_valid),
        .imem_rdata    (imem_rdata),
        .ifid_pc       (ifid_pc),
        .ifid_instr    (ifid_instr),
        .ifid_valid    (ifid_valid),
        .fetch_busy    (fetch_busy)
`ifdef IF_STALL_CNT_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] pc,
                              input logic [31:0] instr, input logic valid);
        check_eq({tag, ".ifid_pc"}, ifid_pc, pc);
        check_eq({tag, ".ifid_instr"}, ifid_instr, instr);
        check_eq({tag, ".ifid_valid"}, 32'(ifid_valid), 32'(valid));
    endtask

    task automatic check_req(input string tag, input logic req, input logic [31:0] addr);
        check_eq({tag, ".imem_req"}, 32'(imem_req), 32'(req));
        if (req) check_eq({tag, ".imem_addr"}, imem_addr, addr);
    endtask

    task automatic set_stall(input logic stall);
        pc_write   = ~stall;
        ifid_write = ~stall;
    endtask

    task automatic respond(input logic [31:0] data);
        imem_valid = 1'b1;
        imem_rdata = data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        branch_taken  = 1'b0;
        branch_target = '0;
        imem_valid    = 1'b0;
        imem_rdata    = '0;

        // Reset state
        step();
        step();
        check_req("rst", 1'b0, 32'h0);
        check_eq("rst.imem_addr", imem_addr, 32'h0);
        check_eq("rst.fetch_busy", 32'(fetch_busy), 32'd0);
        check_ifid("rst", 32'h0, NOP, 1'b0);
`ifdef IF_STALL_CNT_EN
        check_eq("rst.stall_cnt", stall_cnt, 32'd0);
`endif

        // First fetch with 1-cycle memory
        rst_n = 1'b1;
        #1;
        check_req("f0.req", 1'b1, 32'h0);
        step();
        check_req("f0.wait", 1'b0, 32'h0);
        check_eq("f0.busy", 32'(fetch_busy), 32'd1);
        respond(32'h0050_0093);
        step();
        imem_valid = 1'b0;
        check_ifid("f0.load", 32'h0, 32'h0050_0093, 1'b1);
        check_req("f0.next", 1'b1, 32'h4);
        check_eq("f0.busy_done", 32'(fetch_busy), 32'd0);

        // Response during a 3-cycle stall goes through the hold buffer
        step();
        check_ifid("h.bubble", 32'h0, NOP, 1'b0);
        respond(32'h00A0_0113);
        set_stall(1'b1);
        step();
        imem_valid = 1'b0;
        check_req("h.hold1", 1'b0, 32'h0);
        check_eq("h.busy", 32'(fetch_busy), 32'd0);
        check_ifid("h.hold1", 32'h0, NOP, 1'b0);
        step();
        step();
        check_req("h.hold3", 1'b0, 32'h0);
        check_ifid("h.hold3", 32'h0, NOP, 1'b0);
        set_stall(1'b0);
        step();
        check_ifid("h.release", 32'h4, 32'h00A0_0113, 1'b1);
        check_req("h.release", 1'b1, 32'h8);

        // Branch in S_WAIT, response arrives two cycles later and is dropped
        step();
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0103;
        step();
        branch_taken = 1'b0;
        check_eq("b1.busy", 32'(fetch_busy), 32'd1);
        check_req("b1.noreq", 1'b0, 32'h0);
        check_eq("b1.ifid_valid", 32'(ifid_valid), 32'd0);
        step();
        check_eq("b1.still_wait", 32'(fetch_busy), 32'd1);
        respond(32'hDEAD_BEEF);
        step();
        imem_valid = 1'b0;
        check_ifid("b1.drop", 32'h4, NOP, 1'b0);
        check_req("b1.refetch", 1'b1, 32'h100);

        // Branch together with imem_valid and a stall
        step();
        respond(32'h1111_1111);
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0200;
        set_stall(1'b1);
        step();
        imem_valid   = 1'b0;
        branch_taken = 1'b0;
        set_stall(1'b0);
        check_req("b2.refetch", 1'b1, 32'h200);
        check_eq("b2.ifid_valid", 32'(ifid_valid), 32'd0);
        check_eq("b2.ifid_instr", ifid_instr, NOP);
        step();
        respond(32'h2222_2222);
        step();
        imem_valid = 1'b0;
        check_ifid("b2.nosquash", 32'h200, 32'h2222_2222, 1'b1);
        check_req("b2.next", 1'b1, 32'h204);

        // Branch from S_REQ, then a second branch while squash is pending
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0300;
        step();
        check_eq("b3.busy", 32'(fetch_busy), 32'd1);
        branch_target = 32'h0000_0400;
        step();
        branch_taken = 1'b0;
        check_eq("b3.busy2", 32'(fetch_busy), 32'd1);
        respond(32'h3333_3333);
        step();
        imem_valid = 1'b0;
        check_ifid("b3.drop", 32'h200, NOP, 1'b0);
        check_req("b3.refetch", 1'b1, 32'h400);
        step();
        respond(32'h4444_4444);
        step();
        imem_valid = 1'b0;
        check_ifid("b3.load", 32'h400, 32'h4444_4444, 1'b1);

        // Branch from S_HOLD discards the buffered instruction
        step();
        respond(32'h5555_5555);
        set_stall(1'b1);
        step();
        imem_valid    = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0500;
        step();
        branch_taken = 1'b0;
        set_stall(1'b0);
        check_req("b4.refetch", 1'b1, 32'h500);
        check_ifid("b4.bubble", 32'h400, NOP, 1'b0);

        // PC wrap at the top of the address space (target LSBs ignored)
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFF;
        step();
        branch_taken = 1'b0;
        respond(32'h0);
        step();
        imem_valid = 1'b0;
        check_req("w.req", 1'b1, 32'hFFFF_FFFC);
        step();
        respond(32'h0010_0073);
        step();
        imem_valid = 1'b0;
        check_ifid("w.load", 32'hFFFF_FFFC, 32'h0010_0073, 1'b1);
        check_req("w.wrap", 1'b1, 32'h0);

        // Reset asserted mid-S_WAIT; late response after release is ignored
        step();
        check_eq("r.busy", 32'(fetch_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_req("r.async", 1'b0, 32'h0);
        check_eq("r.addr", imem_addr, 32'h0);
        check_eq("r.busy0", 32'(fetch_busy), 32'd0);
        check_ifid("r.async", 32'h0, NOP, 1'b0);
        respond(32'h6666_6666);
        step();
        rst_n = 1'b1;
        step();
        imem_valid = 1'b0;
        check_eq("r.wait", 32'(fetch_busy), 32'd1);
        check_ifid("r.ignored", 32'h0, NOP, 1'b0);
        respond(32'h7777_7777);
        step();
        imem_valid = 1'b0;
        check_ifid("r.load", 32'h0, 32'h7777_7777, 1'b1);
        check_req("r.next", 1'b1, 32'h4);

        // Five stall cycles with no response
        set_stall(1'b1);
        repeat (5) step();
        check_ifid("s.hold", 32'h0, 32'h7777_7777, 1'b1);
        check_eq("s.busy", 32'(fetch_busy), 32'd1);
`ifdef IF_STALL_CNT_EN
        check_eq("s.stall_cnt", stall_cnt, 32'd5);
`endif
        set_stall(1'b0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
